rsa_crt_decrypt: RTL and testbench

- RSA decryption engine: the receive-side counterpart of the RSA encrypt block.
- Recovers plaintext M = C^d mod N using the Chinese Remainder Theorem (Garner recombination) from private-key components P, Q, Dp, Dq and Qinv.
- Sits after the ciphertext path. Uses a start/busy/Done handshake, and its Result/Done pair matches the encrypt block's output convention.
- A single modular-exponentiation sub-unit is time-shared: first the mod-P half, then the mod-Q half.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/mod_exp_unit.sv | 68 ++++++
 rtl/rsa_crt_decrypt.sv | 160 ++++++++++++++++
 tb/tb_rsa_crt_decrypt.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA CRT decryption engine.
// Holds the FSM state type and the default operand widths.
package rsa_pkg;

  localparam int unsigned DEF_WIDTH = 6;
  localparam int unsigned DEF_KEYW  = 6;

  // Each CRT half carries half of the modulus width.
  function automatic int unsigned half_of(input int unsigned w);
    return w / 2;
  endfunction

  localparam int unsigned DEF_HALF = half_of(DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXP_P   = 3'd1,
    EXP_Q   = 3'd2,
    COMBINE = 3'd3,
    FINISH  = 3'd4
  } state_e;

endpackage

// File: rtl/mod_exp_unit.sv
// MSB-first square-and-multiply modular exponentiation, one exponent bit per cycle.
// The first bit is consumed on the load edge, so acc is final KEYW-1 edges after load.
module mod_exp_unit
  import rsa_pkg::*;
#(
  parameter int unsigned HALF = DEF_HALF,
  parameter int unsigned KEYW = DEF_KEYW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [HALF-1:0] base,
  input  logic [KEYW-1:0] exp,
  input  logic [HALF-1:0] mod,
  output logic [HALF-1:0] acc,
  output logic            done
);

  localparam int unsigned CW = $clog2(KEYW + 1);

  logic [HALF-1:0]   r_base;
  logic [HALF-1:0]   r_mod;
  logic [KEYW-1:0]   r_exp;
  logic [CW-1:0]     r_cnt;

  logic [HALF-1:0]   w_base;
  logic [HALF-1:0]   w_mod;
  logic [HALF-1:0]   w_acc_in;
  logic              w_bit;
  logic [2*HALF-1:0] w_sq;
  logic [2*HALF-1:0] w_mul;
  logic [HALF-1:0]   w_acc_next;

  // One step: acc^2 mod m, then times base mod m when the current bit is set.
  always_comb begin
    w_base     = load ? base : r_base;
    w_mod      = load ? mod  : r_mod;
    w_acc_in   = load ? HALF'(1) : acc;
    w_bit      = load ? exp[KEYW-1] : r_exp[KEYW-1];
    w_sq       = ({{HALF{1'b0}}, w_acc_in} * {{HALF{1'b0}}, w_acc_in}) % {{HALF{1'b0}}, w_mod};
    w_mul      = (w_sq * {{HALF{1'b0}}, w_base}) % {{HALF{1'b0}}, w_mod};
    w_acc_next = w_bit ? HALF'(w_mul) : HALF'(w_sq);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base <= '0;
      r_mod  <= '0;
      r_exp  <= '0;
      r_cnt  <= '0;
      acc    <= '0;
      done   <= 1'b0;
    end else if (load) begin
      r_base <= base;
      r_mod  <= mod;
      r_exp  <= exp << 1;
      r_cnt  <= CW'(KEYW - 1);
      acc    <= w_acc_next;
      done   <= (KEYW == 1);
    end else if (r_cnt != '0) begin
      r_exp  <= r_exp << 1;
      r_cnt  <= r_cnt - CW'(1);
      acc    <= w_acc_next;
      done   <= (r_cnt == CW'(1));
    end
  end

endmodule

// File: rtl/rsa_crt_decrypt.sv
// RSA decryption via CRT: C^Dp mod P, then C^Dq mod Q on one shared
// exponentiation unit, recombined with Garner's formula.
module rsa_crt_decrypt
  import rsa_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned KEYW  = DEF_KEYW,
  localparam int unsigned HALF  = half_of(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Cipher,
  input  logic [HALF-1:0]  P,
  input  logic [HALF-1:0]  Q,
  input  logic [KEYW-1:0]  Dp,
  input  logic [KEYW-1:0]  Dq,
  input  logic [HALF-1:0]  Qinv,
  output logic             busy,
  output logic [WIDTH-1:0] Result,
  output logic             Done,
  output logic             Err
);

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_cipher;
  logic [HALF-1:0]  r_p;
  logic [HALF-1:0]  r_q;
  logic [HALF-1:0]  r_qinv;
  logic [KEYW-1:0]  r_dq;
  logic [HALF-1:0]  r_m1;
  logic [HALF-1:0]  r_m2;
  logic             r_err;

  logic             w_accept;
  logic             w_ops_ok;
  logic             w_load;
  logic [HALF-1:0]  w_ld_base;
  logic [HALF-1:0]  w_ld_mod;
  logic [KEYW-1:0]  w_ld_exp;
  logic [HALF-1:0]  w_acc;
  logic             w_exp_done;
  logic             w_busy_d;
  logic             w_done_d;
  logic             w_err_d;

  logic [HALF-1:0]  w_m2p;
  logic [HALF:0]    w_diff;
  logic [HALF-1:0]  w_h;
  logic [WIDTH-1:0] w_result;

  mod_exp_unit #(
    .HALF (HALF),
    .KEYW (KEYW)
  ) u_exp (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .base  (w_ld_base),
    .exp   (w_ld_exp),
    .mod   (w_ld_mod),
    .acc   (w_acc),
    .done  (w_exp_done)
  );

  // Next-state, unit load control and next values of the registered outputs.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ld_base    = '0;
    w_ld_exp     = '0;
    w_ld_mod     = '0;
    w_accept     = 1'b0;
    w_ops_ok     = (P >= HALF'(2)) && (Q >= HALF'(2));
    w_done_d     = 1'b0;
    w_err_d      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (!w_ops_ok) begin
            w_state_next = FINISH;
          end else begin
            w_state_next = EXP_P;
            w_load       = 1'b1;
            w_ld_base    = HALF'(Cipher % WIDTH'(P));
            w_ld_exp     = Dp;
            w_ld_mod     = P;
          end
        end
      end
      EXP_P: begin
        if (w_exp_done) begin
          w_state_next = EXP_Q;
          w_load       = 1'b1;
          w_ld_base    = HALF'(r_cipher % WIDTH'(r_q));
          w_ld_exp     = r_dq;
          w_ld_mod     = r_q;
        end
      end
      EXP_Q: begin
        if (w_exp_done) w_state_next = COMBINE;
      end
      COMBINE: w_state_next = FINISH;
      FINISH: begin
        w_state_next = IDLE;
        w_done_d     = 1'b1;
        w_err_d      = r_err;
      end
      default: w_state_next = IDLE;
    endcase
    w_busy_d = (w_state_next != IDLE);
  end

  // Garner recombination; m1 + P - (m2 mod P) keeps the difference non-negative.
  always_comb begin
    w_m2p    = r_m2 % r_p;
    w_diff   = ({1'b0, r_m1} + {1'b0, r_p} - {1'b0, w_m2p}) % {1'b0, r_p};
    w_h      = HALF'((WIDTH'(r_qinv) * WIDTH'(w_diff)) % WIDTH'(r_p));
    w_result = WIDTH'(r_m2) + WIDTH'(r_q) * WIDTH'(w_h);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cipher <= '0;
      r_p      <= '0;
      r_q      <= '0;
      r_qinv   <= '0;
      r_dq     <= '0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_err    <= 1'b0;
      busy     <= 1'b0;
      Result   <= '0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      busy    <= w_busy_d;
      Done    <= w_done_d;
      Err     <= w_err_d;
      if (w_accept) begin
        r_cipher <= Cipher;
        r_p      <= P;
        r_q      <= Q;
        r_qinv   <= Qinv;
        r_dq     <= Dq;
        r_err    <= !w_ops_ok;
        if (!w_ops_ok) Result <= '0;
      end
      if (r_state == EXP_P && w_exp_done) r_m1 <= w_acc;
      if (r_state == EXP_Q && w_exp_done) r_m2 <= w_acc;
      if (r_state == COMBINE) Result <= w_result;
    end
  end

endmodule

// File: tb/tb_rsa_crt_decrypt.sv
// Self-checking bench for rsa_crt_decrypt: directed cases plus random keys
// checked against a brute-force CRT reference model.
module tb_rsa_crt_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] Cipher;
  logic [2:0] P;
  logic [2:0] Q;
  logic [5:0] Dp;
  logic [5:0] Dq;
  logic [2:0] Qinv;
  logic       busy;
  logic [5:0] Result;
  logic       Done;
  logic       Err;

  int n_checks = 0;
  int n_fail   = 0;

  rsa_crt_decrypt dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Cipher (Cipher),
    .P      (P),
    .Q      (Q),
    .Dp     (Dp),
    .Dq     (Dq),
    .Qinv   (Qinv),
    .busy   (busy),
    .Result (Result),
    .Done   (Done),
    .Err    (Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: plain repeated multiplication, then search for the unique CRT value.
  function automatic int powmod(input int b, input int e, input int m);
    int r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int crt_ref(input int c, input int p, input int q, input int dp, input int dq);
    int m1 = powmod(c % p, dp, p);
    int m2 = powmod(c % q, dq, q);
    for (int x = 0; x < p * q; x++)
      if ((x % p) == m1 && (x % q) == m2) return x;
    return -1;
  endfunction

  function automatic int qinv_of(input int p, input int q);
    for (int x = 0; x < p; x++)
      if (((x * q) % p) == 1) return x;
    return 0;
  endfunction

  task automatic launch(input int c, input int p, input int q, input int dp, input int dq, input int qi);
    Cipher = 6'(c); P = 3'(p); Q = 3'(q); Dp = 6'(dp); Dq = 6'(dq); Qinv = 3'(qi);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (Done) break;
      if (!busy) busy_ok = 1'b0;
    end
    if (!Done) lat = 99;
  endtask

  task automatic run_check(input string tag, input int c, input int p, input int q,
                           input int dp, input int dq, input int qi,
                           input int exp_res, input bit exp_err, input int exp_lat);
    int lat;
    bit bok;
    launch(c, p, q, dp, dq, qi);
    wait_done(lat, bok);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_during"}, 32'(bok), 32'd1);
    chk({tag, "_result"}, 32'(Result), exp_res);
    chk({tag, "_err"}, 32'(Err), 32'(exp_err));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int dn;
    bit bok;
    reset = 1'b0; start = 1'b0;
    Cipher = '0; P = '0; Q = '0; Dp = '0; Dq = '0; Qinv = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 32'(Result), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_check("c32", 32, 5, 7, 1, 5, 3, 2, 1'b0, 14);
    run_check("c17_wrap", 17, 5, 7, 1, 5, 3, 12, 1'b0, 14);
    run_check("c0", 0, 5, 7, 1, 5, 3, 0, 1'b0, 14);
    run_check("exp0", 17, 5, 7, 0, 0, 3, 1, 1'b0, 14);
    run_check("c_over_range", 63, 5, 7, 1, 5, 3, crt_ref(63, 5, 7, 1, 5), 1'b0, 14);

    run_check("err_p1", 20, 1, 7, 1, 5, 3, 0, 1'b1, 1);
    @(posedge clk); #1;
    chk("err_pulse_done_low", 32'(Done), 0);
    chk("err_pulse_err_low", 32'(Err), 0);

    // Start re-pulsed with different operands mid-run must be ignored.
    launch(32, 5, 7, 1, 5, 3);
    lat = 0;
    while (lat < 40) begin
      if (lat == 4) begin
        start = 1'b1; Cipher = 6'd11; P = 3'd3; Q = 3'd5; Dp = 6'd2; Dq = 6'd3; Qinv = 3'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (Done) break;
    end
    start = 1'b0;
    if (!Done) lat = 99;
    chk("midrun_latency", lat, 14);
    chk("midrun_result", 32'(Result), 2);
    // Back-to-back: start presented during the Done cycle.
    run_check("b2b", 17, 5, 7, 1, 5, 3, 12, 1'b0, 14);

    // Reset in the middle of an operation.
    launch(17, 5, 7, 1, 5, 3);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset_result", 32'(Result), 0);
    chk("midreset_done", 32'(Done), 0);
    chk("midreset_busy", 32'(busy), 0);
    reset = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (Done) dn++;
    end
    chk("midreset_no_done", dn, 0);
    run_check("after_reset", 32, 5, 7, 1, 5, 3, 2, 1'b0, 14);

    // Random keys over distinct small primes, checked against the model.
    for (int t = 0; t < 12; t++) begin
      int primes[4] = '{2, 3, 5, 7};
      int p, q, c, dp, dq, qi;
      p = primes[$urandom_range(0, 3)];
      do q = primes[$urandom_range(0, 3)]; while (q == p);
      c  = int'($urandom_range(0, p * q - 1));
      dp = int'($urandom_range(0, 63));
      dq = int'($urandom_range(0, 63));
      qi = qinv_of(p, q);
      run_check($sformatf("rand%0d", t), c, p, q, dp, dq, qi, crt_ref(c, p, q, dp, dq), 1'b0, 14);
    end

    wait_done(lat, bok);
    chk("idle_no_spurious_done", lat, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
